// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch/execute signals between the core and the branch predict unit
//   master (core): drives PCF and the E-stage resolve inputs, receives prediction/redirect/stats
//   slave  (unit): receives PCF/E-stage inputs, drives PredTakenF/PredTargetF, PCSrcE,
//                  MispredictE, RedirectPCE, BranchCnt, MispredCnt
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  PCF;
    logic             PredTakenF;
    logic [XLEN-1:0]  PredTargetF;
    logic             ValidE;
    logic             BranchE;
    logic             JumpE;
    logic [2:0]       funct3E;
    logic             ZeroE;
    logic             ALUResultEb0;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCTargetE;
    logic             PredTakenE;
    logic [XLEN-1:0]  PredTargetE;
    logic             PCSrcE;
    logic             MispredictE;
    logic [XLEN-1:0]  RedirectPCE;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] MispredCnt;
    modport master (
        output PCF, ValidE, BranchE, JumpE, funct3E, ZeroE, ALUResultEb0, PCE, PCTargetE,
               PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, PCSrcE, MispredictE, RedirectPCE, BranchCnt, MispredCnt
    );
    modport slave (
        input  PCF, ValidE, BranchE, JumpE, funct3E, ZeroE, ALUResultEb0, PCE, PCTargetE,
               PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, PCSrcE, MispredictE, RedirectPCE, BranchCnt, MispredCnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped branch predictor with E-stage resolve, redirect and training
//   clk, rst_n : core clock, asynchronous active-low reset
//   bp (slave) : F-stage lookup (PCF -> PredTakenF/PredTargetF), E-stage resolve
//                (-> PCSrcE/MispredictE/RedirectPCE) and saturating BranchCnt/MispredCnt
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 32,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst_n,
    branch_predict_unit_if.slave bp
);
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic [1:0]       ctr_e, ctr_d;
    logic             hit_f, hit_e, cond_e, ctrl_e, upd_e;
    logic             unused_ok;

    assign idx_f          = bp.PCF[TAG_LO-1:2];
    assign tag_f          = bp.PCF[TAG_LO+TAG_W-1:TAG_LO];
    assign hit_f          = valid_q[idx_f] && tag_q[idx_f] == tag_f;
    assign bp.PredTakenF  = hit_f && ctr_q[idx_f][1];
    assign bp.PredTargetF = bp.PredTakenF ? target_q[idx_f] : bp.PCF + XLEN'(4);

    // funct3[2] picks the slt/sltu flag, funct3[0] inverts the sense; 010/011 never take
    assign cond_e         = bp.funct3E[2] ? bp.ALUResultEb0 ^ bp.funct3E[0]
                                          : !bp.funct3E[1] && (bp.ZeroE ^ bp.funct3E[0]);
    assign ctrl_e         = bp.ValidE && (bp.BranchE || bp.JumpE);
    assign bp.PCSrcE      = bp.ValidE && (bp.BranchE ? cond_e : bp.JumpE);
    assign bp.MispredictE = ctrl_e && (bp.PCSrcE != bp.PredTakenE ||
                                       (bp.PCSrcE && bp.PredTargetE != bp.PCTargetE));
    assign bp.RedirectPCE = bp.PCSrcE ? bp.PCTargetE : bp.PCE + XLEN'(4);

    assign idx_e = bp.PCE[TAG_LO-1:2];
    assign tag_e = bp.PCE[TAG_LO+TAG_W-1:TAG_LO];
    assign hit_e = valid_q[idx_e] && tag_q[idx_e] == tag_e;
    assign ctr_e = ctr_q[idx_e];
    // a not-taken miss is not worth an entry; everything else resolved in E writes one
    assign upd_e = ctrl_e && (hit_e || bp.PCSrcE);
    // jumps always go strongly taken; fresh branches start weakly taken
    assign ctr_d = !bp.BranchE ? 2'b11 :
                   !hit_e      ? 2'b10 :
                   bp.PCSrcE   ? (ctr_e == 2'b11 ? ctr_e : ctr_e + 2'd1)
                               : (ctr_e == 2'b00 ? ctr_e : ctr_e - 2'd1);

    assign branch_cnt_d  = branch_cnt_q + CNT_W'(ctrl_e && !(&branch_cnt_q));
    assign mispred_cnt_d = mispred_cnt_q + CNT_W'(bp.MispredictE && !(&mispred_cnt_q));
    assign bp.BranchCnt  = branch_cnt_q;
    assign bp.MispredCnt = mispred_cnt_q;

    // index bits below and tag bits above the used slices are deliberately ignored
    assign unused_ok = ^{bp.PCF, bp.PCE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (upd_e) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
                ctr_q[idx_e]   <= ctr_d;
                if (bp.PCSrcE) target_q[idx_e] <= bp.PCTargetE;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scenario tasks driving the branch predict unit against hand-derived expectations
module tb_branch_predict_unit;
    typedef struct {
        logic [31:0] pcf;
        logic        v, br, jp;
        logic [2:0]  f3;
        logic        z, b0;
        logic [31:0] pce, tgt;
        logic        pte;
        logic [31:0] ptge;
        logic [66:0] ev;
    } row_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [66:0] exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [3:0]  exp_bc = 4'd0;
    logic [3:0]  exp_mc = 4'd0;
    logic        pend_ctrl = 1'b0;
    logic        pend_mis  = 1'b0;

    branch_predict_unit_if #(.XLEN(32), .CNT_W(4)) bp ();
    branch_predict_unit #(.XLEN(32), .ENTRIES(32), .TAG_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bp(bp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // {PredTakenF, PredTargetF, PCSrcE, MispredictE, RedirectPCE}
    function automatic logic [66:0] mk(input logic pt, input logic [31:0] ptg, input logic src,
                                       input logic mis, input logic [31:0] rpc);
        return {pt, ptg, src, mis, rpc};
    endfunction

    function automatic row_t r(input logic [31:0] pcf, input logic v, br, jp, input logic [2:0] f3,
                               input logic z, b0, input logic [31:0] pce, tgt, input logic pte,
                               input logic [31:0] ptge, input logic [66:0] ev);
        return '{pcf, v, br, jp, f3, z, b0, pce, tgt, pte, ptge, ev};
    endfunction

    function automatic row_t ri(input logic [31:0] pcf, input logic [66:0] ev);
        return r(pcf, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, ev);
    endfunction

    function automatic logic [66:0] act();
        return {bp.PredTakenF, bp.PredTargetF, bp.PCSrcE, bp.MispredictE, bp.RedirectPCE};
    endfunction

    task automatic drive(input row_t x);
        @(negedge clk);
        if (pend_ctrl && exp_bc != 4'hF) exp_bc++;
        if (pend_mis && exp_mc != 4'hF) exp_mc++;
        bp.PCF          = x.pcf;
        bp.ValidE       = x.v;
        bp.BranchE      = x.br;
        bp.JumpE        = x.jp;
        bp.funct3E      = x.f3;
        bp.ZeroE        = x.z;
        bp.ALUResultEb0 = x.b0;
        bp.PCE          = x.pce;
        bp.PCTargetE    = x.tgt;
        bp.PredTakenE   = x.pte;
        bp.PredTargetE  = x.ptge;
        pend_ctrl = rst_n && x.v && (x.br || x.jp);
        pend_mis  = rst_n && x.ev[32];
        exp_q.push_back(x.ev);
        #1;
    endtask

    task automatic test_reset();
        row_t rs [$];
        logic [66:0] e;
        rs.push_back(ri(32'h100, mk(0, 32'h104, 0, 0, 32'h4)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 0, 32'h44, mk(0, 32'h104, 1, 1, 32'h80)));
        rs.push_back(ri(32'h40, mk(0, 32'h44, 0, 0, 32'h4)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== 4'd0 || bp.MispredCnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", bp.BranchCnt, bp.MispredCnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_train();
        row_t rs [$];
        logic [66:0] e;
        rs.push_back(r(32'h100, 1, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 0, 32'h44, mk(0, 32'h104, 1, 1, 32'h80)));
        rs.push_back(ri(32'h40, mk(1, 32'h80, 0, 0, 32'h4)));
        rs.push_back(r(32'h40, 1, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 1, 32'h80, mk(1, 32'h80, 1, 0, 32'h80)));
        rs.push_back(r(32'h40, 1, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 1, 32'h80, mk(1, 32'h80, 1, 0, 32'h80)));
        rs.push_back(r(32'h40, 1, 1, 0, 3'b000, 0, 0, 32'h40, 32'h80, 1, 32'h80, mk(1, 32'h80, 0, 1, 32'h44)));
        rs.push_back(ri(32'h40, mk(1, 32'h80, 0, 0, 32'h4)));
        rs.push_back(r(32'h40, 1, 1, 0, 3'b000, 0, 0, 32'h40, 32'h80, 1, 32'h80, mk(1, 32'h80, 0, 1, 32'h44)));
        rs.push_back(ri(32'h40, mk(0, 32'h44, 0, 0, 32'h4)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL train[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL train_stats got %0d/%0d want %0d/%0d", bp.BranchCnt, bp.MispredCnt, exp_bc, exp_mc);
        end
    endtask

    task automatic test_conditions();
        row_t rs [$];
        logic [66:0] e;
        rs.push_back(r(32'h100, 1, 1, 0, 3'b001, 1, 0, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 0, 0, 32'h204)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b001, 0, 0, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 1, 1, 32'h300)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b100, 0, 1, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 1, 1, 32'h300)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b100, 1, 0, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 0, 0, 32'h204)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b110, 0, 1, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 1, 1, 32'h300)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b101, 0, 1, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 0, 0, 32'h204)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b111, 0, 0, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 1, 1, 32'h300)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b000, 0, 1, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 0, 0, 32'h204)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b010, 1, 1, 32'h600, 32'h700, 0, 32'h604, mk(0, 32'h104, 0, 0, 32'h604)));
        rs.push_back(r(32'h100, 1, 1, 0, 3'b011, 1, 1, 32'h600, 32'h700, 0, 32'h604, mk(0, 32'h104, 0, 0, 32'h604)));
        rs.push_back(ri(32'h600, mk(0, 32'h604, 0, 0, 32'h4)));
        rs.push_back(r(32'h100, 0, 1, 0, 3'b000, 1, 0, 32'h200, 32'h300, 0, 32'h204, mk(0, 32'h104, 0, 0, 32'h204)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL cond[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL cond_stats got %0d/%0d want %0d/%0d", bp.BranchCnt, bp.MispredCnt, exp_bc, exp_mc);
        end
    endtask

    task automatic test_alias();
        row_t rs [$];
        logic [66:0] e;
        rs.push_back(r(32'h100, 1, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 0, 32'h44, mk(0, 32'h104, 1, 1, 32'h80)));
        rs.push_back(ri(32'h40, mk(1, 32'h80, 0, 0, 32'h4)));
        rs.push_back(ri(32'hC0, mk(0, 32'hC4, 0, 0, 32'h4)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL alias[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL alias_stats got %0d/%0d want %0d/%0d", bp.BranchCnt, bp.MispredCnt, exp_bc, exp_mc);
        end
    endtask

    task automatic test_jump();
        row_t rs [$];
        logic [66:0] e;
        rs.push_back(r(32'h100, 1, 0, 1, 3'b000, 0, 0, 32'h500, 32'h900, 0, 32'h504, mk(0, 32'h104, 1, 1, 32'h900)));
        rs.push_back(ri(32'h500, mk(1, 32'h900, 0, 0, 32'h4)));
        rs.push_back(r(32'h500, 1, 0, 1, 3'b000, 0, 0, 32'h500, 32'hA00, 1, 32'h900, mk(1, 32'h900, 1, 1, 32'hA00)));
        rs.push_back(ri(32'h500, mk(1, 32'hA00, 0, 0, 32'h4)));
        rs.push_back(r(32'h500, 1, 0, 1, 3'b000, 0, 0, 32'h500, 32'hA00, 1, 32'hA00, mk(1, 32'hA00, 1, 0, 32'hA00)));
        rs.push_back(r(32'h500, 1, 1, 1, 3'b010, 1, 1, 32'h500, 32'hA00, 0, 32'h504, mk(1, 32'hA00, 0, 0, 32'h504)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL jump[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL jump_stats got %0d/%0d want %0d/%0d", bp.BranchCnt, bp.MispredCnt, exp_bc, exp_mc);
        end
    endtask

    task automatic test_saturation();
        row_t rs [$];
        logic [66:0] e;
        for (int k = 0; k < 7; k++)
            rs.push_back(r(32'h100, 1, 0, 1, 3'b000, 0, 0, 32'h700, 32'h800, 0, 32'h704, mk(0, 32'h104, 1, 1, 32'h800)));
        rs.push_back(ri(32'h100, mk(0, 32'h104, 0, 0, 32'h4)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL sat[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL sat_stats got %0d/%0d want %0d/%0d", bp.BranchCnt, bp.MispredCnt, exp_bc, exp_mc);
        end
    endtask

    task automatic test_reset_mid();
        row_t rs [$];
        logic [66:0] e;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        exp_bc    = 4'd0;
        exp_mc    = 4'd0;
        pend_ctrl = 1'b0;
        pend_mis  = 1'b0;
        #1;
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL async_reset_stats got %0d/%0d want 0/0", bp.BranchCnt, bp.MispredCnt);
        end
        rs.push_back(ri(32'h40, mk(0, 32'h44, 0, 0, 32'h4)));
        rs.push_back(ri(32'h500, mk(0, 32'h504, 0, 0, 32'h4)));
        rs.push_back(r(32'h40, 1, 1, 0, 3'b000, 1, 0, 32'h40, 32'h80, 0, 32'h44, mk(0, 32'h44, 1, 1, 32'h80)));
        rs.push_back(ri(32'h40, mk(0, 32'h44, 0, 0, 32'h4)));
        foreach (rs[i]) begin
            drive(rs[i]);
            e = exp_q.pop_front();
            n_chk++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] got %h want %h", i, act(), e);
            end
        end
        n_chk++;
        if (bp.BranchCnt !== exp_bc || bp.MispredCnt !== exp_mc) begin
            n_fail++;
            $display("FAIL reset_mid_stats got %0d/%0d want 0/0", bp.BranchCnt, bp.MispredCnt);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bp.PCF          = 32'h0;
        bp.ValidE       = 1'b0;
        bp.BranchE      = 1'b0;
        bp.JumpE        = 1'b0;
        bp.funct3E      = 3'b000;
        bp.ZeroE        = 1'b0;
        bp.ALUResultEb0 = 1'b0;
        bp.PCE          = 32'h0;
        bp.PCTargetE    = 32'h0;
        bp.PredTakenE   = 1'b0;
        bp.PredTargetE  = 32'h0;
        test_reset();
        test_train();
        test_conditions();
        test_alias();
        test_jump();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
